// File: rtl/uart_rx_wb.sv
// uart_rx_wb: 8N1 serial receiver with 16x oversampling,
// an 8-entry byte FIFO and a two-register Wishbone slave.
module uart_rx_wb #(
  parameter int CLK_FREQ_HZ = 24000000,
  parameter int BAUD        = 115200,
  parameter int DIVISOR     = CLK_FREQ_HZ / (16 * BAUD),
  parameter int FIFO_AW     = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        uart_rx,
  input  logic [2:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        irq_o
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [15:0] DIV_LAST = 16'(DIVISOR - 1);
  localparam logic [FIFO_AW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_n;

  logic rx_s1, rx_s2, rx_s3;
  logic [15:0] div_cnt;
  logic [3:0]  samp_cnt;
  logic tick, mid;
  logic start_det, shift_en, push_req, ferr_set;
  logic [7:0] shreg;
  logic [2:0] bit_idx;

  logic [7:0] mem [DEPTH];
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic nempty, full, ovr, ferr;
  logic access, pop, push, wr_stat;
  logic [31:0] status;

  logic unused_ok;
  assign unused_ok = ^{wb_sel_i, wb_adr_i[1:0],
                       wb_dat_i[31:4], wb_dat_i[1:0]};

  // rx_s3 is the previous synced sample, used for edge detection
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= uart_rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign tick = (div_cnt == DIV_LAST);
  assign mid  = tick && (samp_cnt == 4'd7);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (start_det) begin
      div_cnt  <= '0;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= samp_cnt + 4'd1;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n   = state;
    start_det = 1'b0;
    shift_en  = 1'b0;
    push_req  = 1'b0;
    ferr_set  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rx_s3 && !rx_s2) begin
          start_det = 1'b1;
          state_n   = START;
        end
      end
      START: begin
        if (mid) state_n = rx_s2 ? IDLE : DATA;
      end
      DATA: begin
        if (mid) begin
          shift_en = 1'b1;
          if (bit_idx == 3'd7) state_n = STOP;
        end
      end
      STOP: begin
        // leave half a bit early so the next start edge is caught
        if (mid) begin
          state_n  = IDLE;
          push_req = rx_s2;
          ferr_set = !rx_s2;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      shreg   <= '0;
      bit_idx <= '0;
    end else if (state != DATA) begin
      bit_idx <= '0;
    end else if (shift_en) begin
      shreg   <= {rx_s2, shreg[7:1]};
      bit_idx <= bit_idx + 3'd1;
    end
  end

  assign nempty = (wr_ptr != rd_ptr);
  assign full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);

  assign access  = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign pop     = access & ~wb_we_i & ~wb_adr_i[2] & nempty;
  assign wr_stat = access & wb_we_i & wb_adr_i[2];
  // a same-cycle pop frees the slot the push would otherwise miss
  assign push    = push_req & (~full | pop);

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= shreg;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ovr  <= 1'b0;
      ferr <= 1'b0;
    end else begin
      if (push_req && full && !pop)     ovr <= 1'b1;
      else if (wr_stat && wb_dat_i[2])  ovr <= 1'b0;
      if (ferr_set)                     ferr <= 1'b1;
      else if (wr_stat && wb_dat_i[3])  ferr <= 1'b0;
    end
  end

  assign status = {28'h0, ferr, ovr, full, nempty};

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      irq_o    <= 1'b0;
    end else begin
      wb_ack_o <= access;
      irq_o    <= nempty;
      if (access) begin
        if (wb_we_i)          wb_dat_o <= '0;
        else if (wb_adr_i[2]) wb_dat_o <= status;
        else if (nempty)      wb_dat_o <= {24'h0, mem[rd_ptr[FIFO_AW-1:0]]};
        else                  wb_dat_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_wb.sv
// tb_uart_rx_wb: scoreboard bench driving 8N1 frames at
// 16*13 clocks per bit and reading bytes back over Wishbone.
`timescale 1ns/1ps
module tb_uart_rx_wb;

  localparam int BIT = 208;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        uart_rx = 1'b1;
  logic [2:0]  wb_adr_i = '0;
  logic [31:0] wb_dat_i = '0;
  logic [3:0]  wb_sel_i = 4'hf;
  logic        wb_we_i = 1'b0;
  logic        wb_cyc_i = 1'b0;
  logic        wb_stb_i = 1'b0;
  logic [31:0] wb_dat_o;
  logic        wb_ack_o;
  logic        irq_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [7:0] sb [$];

  uart_rx_wb dut (
    .clock    (clock),
    .reset    (reset),
    .uart_rx  (uart_rx),
    .wb_adr_i (wb_adr_i),
    .wb_dat_i (wb_dat_i),
    .wb_sel_i (wb_sel_i),
    .wb_we_i  (wb_we_i),
    .wb_cyc_i (wb_cyc_i),
    .wb_stb_i (wb_stb_i),
    .wb_dat_o (wb_dat_o),
    .wb_ack_o (wb_ack_o),
    .irq_o    (irq_o)
  );

  always #21 clock = ~clock;

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(posedge clock); #1 uart_rx = 1'b0;
    repeat (BIT) @(posedge clock);
    for (int i = 0; i < 8; i++) begin
      #1 uart_rx = b[i];
      repeat (BIT) @(posedge clock);
    end
    #1 uart_rx = stop;
    repeat (BIT) @(posedge clock);
    #1 uart_rx = 1'b1;
  endtask

  task automatic wb_read(input logic [2:0] a, output logic [31:0] d,
                         output int lat);
    @(posedge clock); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = a;
    lat = -1; d = 'x;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (wb_ack_o) begin
        d = wb_dat_o; lat = i;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
  endtask

  task automatic wb_write(input logic [2:0] a, input logic [31:0] v);
    int lat;
    @(posedge clock); #1;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = a; wb_dat_i = v;
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      if (wb_ack_o) begin
        lat = i;
        break;
      end
    end
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    tests_run++;
    if (lat != 0) begin
      tests_failed++;
      $display("FAIL wb_write_ack got lat %0d exp 0", lat);
    end
  endtask

  // scoreboard consumer: read RXDATA, compare against queue head
  task automatic rx_pop(input string name);
    logic [31:0] d, exp;
    int lat;
    exp = 32'h0;
    if (sb.size() > 0) exp = {24'h0, sb.pop_front()};
    wb_read(3'h0, d, lat);
    tests_run++;
    if (lat != 0 || d !== exp) begin
      tests_failed++;
      $display("FAIL %s got %h exp %h lat %0d", name, d, exp, lat);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    int lat;
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({wb_ack_o, wb_dat_o, irq_o} !== 34'h0) begin
      tests_failed++;
      $display("FAIL reset_outputs got %b/%h/%b exp 0/0/0",
               wb_ack_o, wb_dat_o, irq_o);
    end
    reset = 1'b0;
    repeat (5) @(posedge clock);
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_status got %h exp %h", d, 32'h0);
    end
  endtask

  task automatic test_single();
    logic [31:0] d;
    int lat;
    sb.push_back(8'h55);
    send_frame(8'h55, 1'b1);
    tests_run++;
    if (irq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_irq got %b exp 1", irq_o);
    end
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h1) begin
      tests_failed++;
      $display("FAIL single_status got %h exp %h", d, 32'h1);
    end
    rx_pop("single_data");
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h0 || irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_after got %h irq %b exp 0 irq 0", d, irq_o);
    end
  endtask

  task automatic test_overrun();
    logic [31:0] d;
    int lat;
    for (int v = 1; v <= 9; v++) begin
      if (v <= 8) sb.push_back(8'(v));
      send_frame(8'(v), 1'b1);
    end
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h7) begin
      tests_failed++;
      $display("FAIL ovr_status got %h exp %h", d, 32'h7);
    end
    for (int i = 0; i < 8; i++) rx_pop("ovr_data");
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h4) begin
      tests_failed++;
      $display("FAIL ovr_drained got %h exp %h", d, 32'h4);
    end
    wb_write(3'h4, 32'h4);
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL ovr_clear got %h exp %h", d, 32'h0);
    end
  endtask

  task automatic test_frame_error();
    logic [31:0] d;
    int lat;
    send_frame(8'hA3, 1'b0);
    repeat (BIT) @(posedge clock);
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h8 || irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL ferr_status got %h irq %b exp 8 irq 0", d, irq_o);
    end
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h9) begin
      tests_failed++;
      $display("FAIL ferr_next got %h exp %h", d, 32'h9);
    end
    rx_pop("ferr_data");
    wb_write(3'h4, 32'h8);
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL ferr_clear got %h exp %h", d, 32'h0);
    end
  endtask

  task automatic test_glitch();
    logic [31:0] d;
    int lat;
    @(posedge clock); #1 uart_rx = 1'b0;
    repeat (52) @(posedge clock);
    #1 uart_rx = 1'b1;
    repeat (2 * BIT) @(posedge clock);
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h0 || irq_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL glitch got %h irq %b exp 0 irq 0", d, irq_o);
    end
    sb.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    rx_pop("glitch_next");
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int lat;
    logic [7:0] b;
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    tests_run++;
    if (irq_o !== 1'b1) begin
      tests_failed++;
      $display("FAIL rst_pre_irq got %b exp 1", irq_o);
    end
    b = 8'hC4;
    @(posedge clock); #1 uart_rx = 1'b0;
    repeat (BIT) @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      #1 uart_rx = b[i];
      repeat (BIT) @(posedge clock);
    end
    #1 uart_rx = b[4];
    repeat (BIT / 2) @(posedge clock);
    #1 reset = 1'b1; uart_rx = 1'b1;
    sb.delete();
    repeat (3) @(posedge clock);
    #1;
    tests_run++;
    if ({wb_ack_o, wb_dat_o, irq_o} !== 34'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs got %b/%h/%b exp 0/0/0",
               wb_ack_o, wb_dat_o, irq_o);
    end
    reset = 1'b0;
    repeat (20) @(posedge clock);
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_status got %h exp %h", d, 32'h0);
    end
    sb.push_back(8'hC4);
    send_frame(8'hC4, 1'b1);
    rx_pop("rst_mid_data");
  endtask

  task automatic test_empty_read();
    logic [31:0] d;
    int lat;
    wb_read(3'h0, d, lat);
    tests_run++;
    if (lat != 0 || d !== 32'h0) begin
      tests_failed++;
      $display("FAIL empty_read got %h lat %0d exp 0 lat 0", d, lat);
    end
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL empty_status got %h exp %h", d, 32'h0);
    end
    sb.push_back(8'h77);
    send_frame(8'h77, 1'b1);
    rx_pop("empty_next");
  endtask

  task automatic test_back_to_back();
    logic [31:0] d, exp;
    logic ack;
    int lat;
    for (int v = 0; v < 8; v++) begin
      sb.push_back(8'h80 + 8'(v));
      send_frame(8'h80 + 8'(v), 1'b1);
    end
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h3) begin
      tests_failed++;
      $display("FAIL coll_full got %h exp %h", d, 32'h3);
    end
    exp = {24'h0, sb.pop_front()};
    sb.push_back(8'h88);
    // the read's ack edge lands on the stop-bit mid-sample edge
    fork
      send_frame(8'h88, 1'b1);
      begin
        @(posedge clock);
        repeat (1978) @(posedge clock);
        #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0;
        wb_adr_i = 3'h0;
        @(posedge clock); #1;
        ack = wb_ack_o; d = wb_dat_o;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      end
    join
    tests_run++;
    if (ack !== 1'b1 || d !== exp) begin
      tests_failed++;
      $display("FAIL coll_pop got %h ack %b exp %h ack 1", d, ack, exp);
    end
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h3) begin
      tests_failed++;
      $display("FAIL coll_status got %h exp %h", d, 32'h3);
    end
    for (int i = 0; i < 8; i++) rx_pop("coll_drain");
    wb_read(3'h4, d, lat);
    tests_run++;
    if (d !== 32'h0) begin
      tests_failed++;
      $display("FAIL coll_end got %h exp %h", d, 32'h0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_overrun();
    test_frame_error();
    test_glitch();
    test_reset_midframe();
    test_empty_read();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_wb.md
Name: uart_rx_wb

Overview:
- Wishbone-slave UART receiver: the receiving end of the 8N1 serial link the SoC transmits on.
- Deserialises the serial line into an 8-entry byte FIFO that the CPU reads over Wishbone.
- Sits in the wb_clk domain alongside the SoC UART; bring-up and loopback use with the nmon monitor at 115200 baud.

Parameters:
CLK_FREQ_HZ, 24000000, wb clock frequency
BAUD, 115200, serial bit rate
DIVISOR, CLK_FREQ_HZ/(16*BAUD) (truncated, =13 at defaults), clocks per 16x oversample tick; must be >=1
FIFO_AW, 3, log2 FIFO depth (depth 8)

Ports:
clock  in  1  wb clock
reset  in  1  asynchronous, active-high reset
uart_rx  in  1  serial input, idle high, asynchronous to clock
wb_adr_i  in  3  byte address; bit 2 selects register, bits 1:0 ignored
wb_dat_i  in  32  write data
wb_sel_i  in  4  byte selects (ignored; full-word access)
wb_we_i  in  1  write enable
wb_cyc_i  in  1  bus cycle
wb_stb_i  in  1  strobe
wb_dat_o  out  32  read data
wb_ack_o  out  1  acknowledge
irq_o  out  1  high while FIFO non-empty

Behaviour:
- Reset values: wb_ack_o=0, wb_dat_o=0, irq_o=0. FIFO empty, sticky flags cleared, FSM in IDLE. Synchroniser flops reset to 1.
- Input path: 2-flop synchroniser on uart_rx; the FSM uses only the synchronised value.
- Tick generator: counts 0..DIVISOR-1 and pulses tick at DIVISOR-1. Free-running, but restarted at 0 on start-edge detection.
- Sample counter: 4 bits, incremented per tick; mid-bit = count 7.
- FSM states:
  - IDLE: on synced rx 1->0, clear tick and sample counters, go START.
  - START: at mid-bit, if rx=0 go DATA (bit index 0); else glitch, go IDLE with no flag.
  - DATA: sample at each mid-bit (every 16 ticks), shifting LSB-first. After bit 7, go STOP.
  - STOP: at mid-bit, if rx=1 push byte; if rx=0 set FERR and discard byte. Either way go IDLE immediately (half-bit early, for resync).
- Push while full: byte dropped, OVR set. Exception: a simultaneous Wishbone pop in the same cycle frees the slot, so the push succeeds and OVR is not set.
- Register map:
  - 0x0 RXDATA (R): {24'b0, head byte}. A read acked while non-empty pops the FIFO on the ack cycle. Read while empty returns 0 with no pop. Writes ignored.
  - 0x4 STATUS (R/W1C): bit0 NEMPTY, bit1 FULL, bit2 OVR (sticky), bit3 FERR (sticky), others 0. Writing 1 to bit2/bit3 clears that flag. If a set event coincides with a clear in the same cycle, set wins.
- Wishbone handshake: wb_ack_o <= cyc&stb&~wb_ack_o, giving a single-cycle ack 1 clock after strobe. Back-to-back accesses complete every 2 cycles. wb_dat_o is registered and valid with ack. No wait states, no errors.
- FIFO: pointers of FIFO_AW+1 bits, wrapping modulo 2*depth. Full when MSBs differ and the low bits are equal.
- irq_o: registered NEMPTY; rises 1 cycle after the push.
- Reset mid-frame: the partial byte is lost; reception resumes on the next falling edge after reset deasserts.

Test Plan:
- Send 0x55 at 115200, defaults -> within 1 bit-time after the stop mid-bit, irq_o=1 and STATUS=0x1. RXDATA read returns 0x00000055, after which STATUS=0x0 and irq_o=0.
- Send 0x01..0x09 without reading -> STATUS=0x7 (NEMPTY|FULL|OVR). Eight reads return 0x01..0x08 in order. Write 0x4 to STATUS -> STATUS=0x0.
- Frame 0xA3 with stop bit driven 0 -> STATUS=0x8, FIFO empty. Next valid frame 0x3C -> STATUS=0x9, read returns 0x3C.
- Low glitch of 4 ticks (52 clocks) on idle line -> FSM returns to IDLE, STATUS=0x0, no irq.
- Assert reset during data bit 4 of a frame -> all outputs 0 during reset. The following frame 0xC4 is received correctly.
- Read RXDATA while empty -> ack after 1 cycle, dat=0, FIFO pointers unchanged. Full FIFO with pop coinciding with push -> FULL stays 1, OVR stays 0.
